// File: rtl/banco_regs_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// banco_regs_pkg : shared defaults and depth helper for the banco_regs bank
// Rev 1.0
// ---------------------------------------------------------------------------
package banco_regs_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned NREAD_DEF  = 2;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/banco_regs_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// banco_regs_sb : per-register busy scoreboard (honours BANCO_REGS_ZERO_REG_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
module banco_regs_sb
  import banco_regs_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [2**ADDR_W-1:0] busy_next,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Reserve is applied after the write clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
`ifdef BANCO_REGS_ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_next = busy_d;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: rtl/banco_regs_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// banco_regs_param : parametrised register bank, N read ports with bypass and
// busy scoreboard; BANCO_REGS_ZERO_REG_EN hardwires register 0. Rev 1.0
// ---------------------------------------------------------------------------
module banco_regs_param
  import banco_regs_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREAD  = NREAD_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic [NREAD-1:0]        rd_en,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  output logic [2**ADDR_W-1:0]    busy
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_next;
  logic              wr_act;

`ifdef BANCO_REGS_ZERO_REG_EN
  assign wr_act = wr_en && (wr_addr != '0);
`else
  assign wr_act = wr_en;
`endif

  banco_regs_sb #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_act),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy_next (busy_next),
    .busy      (busy)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        regs_q[k] <= '0;
      end
    end else if (wr_act) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_busy_q;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Same-edge write forwards its data so a read never returns the stale value.
    always_comb begin
      rd_data_d = regs_q[addr];
      if (wr_act && (wr_addr == addr)) rd_data_d = wr_data;
`ifdef BANCO_REGS_ZERO_REG_EN
      if (addr == '0) rd_data_d = '0;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_q <= '0;
        rd_busy_q <= 1'b0;
      end else if (rd_en[i]) begin
        rd_data_q <= rd_data_d;
        rd_busy_q <= busy_next[addr];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rd_data_q;
    assign rd_busy[i]                  = rd_busy_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_banco_regs_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_banco_regs_param : randomized scoreboard bench for banco_regs_param
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_banco_regs_param;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int NR    = 2;
  localparam int DEPTH = 4;
`ifdef BANCO_REGS_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic             clock;
  logic             reset_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [DEPTH-1:0] busy;

  banco_regs_param #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NREAD  (NR)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    rbusy;
    logic [DEPTH-1:0] busy;
  } exp_t;

  exp_t q[$];

  // Reference state: register contents, busy set, and what each port last read.
  logic [DW-1:0]    m_reg [DEPTH];
  logic [DEPTH-1:0] m_busy;
  logic [DW-1:0]    m_rd  [NR];
  logic             m_rb  [NR];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m_reg[k] = '0;
    m_busy = '0;
    for (int p = 0; p < NR; p++) begin
      m_rd[p] = '0;
      m_rb[p] = 1'b0;
    end
  endtask

  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra,
                       input logic [NR-1:0] ren, input logic [NR*AW-1:0] raddr);
    exp_t          e;
    logic [AW-1:0] a;
    @(negedge clock);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra;
    rd_en    = ren;
    rd_addr  = raddr;
    // Reads observe the state as it stands after this edge's write and reserve.
    if (we && !(ZERO && wa == 0)) begin
      m_reg[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (re && !(ZERO && ra == 0)) m_busy[ra] = 1'b1;
    for (int p = 0; p < NR; p++) begin
      if (ren[p]) begin
        a       = raddr[p*AW +: AW];
        m_rd[p] = m_reg[a];
        m_rb[p] = m_busy[a];
      end
    end
    for (int p = 0; p < NR; p++) begin
      e.data[p*DW +: DW] = m_rd[p];
      e.rbusy[p]         = m_rb[p];
    end
    e.busy = m_busy;
    q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rd_data", {32'd0, rd_data}, {32'd0, e.data});
        check("rd_busy", {32'd0, rd_busy}, {32'd0, e.rbusy});
        check("busy",    {32'd0, busy},    {32'd0, e.busy});
      end
    end
  end

  initial begin : driver
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    rd_en    = '0;
    rd_addr  = '0;
    model_reset();
    #1;
    check("reset_busy", {60'd0, busy}, 64'd0);
    check("reset_rd_data", {48'd0, rd_data}, 64'd0);
    #16;
    reset_n = 1'b1;

    cycle(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'b00, 4'h0);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b01, {2'd0, 2'd2});
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b00, {2'd1, 2'd1});
    cycle(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 2'b10, {2'd1, 2'd0});
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'b01, {2'd0, 2'd3});
    cycle(1'b1, 2'd3, 8'h11, 1'b0, 2'd0, 2'b00, 4'h0);
    cycle(1'b1, 2'd3, 8'h11, 1'b1, 2'd3, 2'b01, {2'd0, 2'd3});
    cycle(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 2'b00, 4'h0);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b11, {2'd2, 2'd2});
    cycle(1'b1, 2'd0, 8'hFF, 1'b1, 2'd0, 2'b00, 4'h0);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b11, {2'd0, 2'd0});
    cycle(1'b1, 2'd0, 8'h77, 1'b0, 2'd0, 2'b01, {2'd0, 2'd0});
    idle();

    // Asynchronous reset mid-cycle with live state in the bank.
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", {60'd0, busy}, 64'd0);
    check("async_rst_rd_data", {48'd0, rd_data}, 64'd0);
    check("async_rst_rd_busy", {62'd0, rd_busy}, 64'd0);
    model_reset();
    #8;
    reset_n = 1'b1;
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b11, {2'd1, 2'd0});
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b11, {2'd3, 2'd2});

    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
            NR'($urandom), (NR*AW)'($urandom));
    end
    idle();

    @(posedge clock);
    @(posedge clock);
    #2;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
